// File: rtl/scan_line_sequencer.sv
// scan_line_sequencer
// Steps a line counter from a latched first line to a latched last line
// (wrapping modulo 2**CNT_W), holding each line for dwell+1 cycles, and
// drives the matching active-low one-cold select bus. A start/abort/done
// handshake faces the host. All outputs come straight from flops.
module scan_line_sequencer #(
  parameter int CNT_W   = 7,
  parameter int SEL_N   = 128,   // must equal 2**CNT_W
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_W-1:0]   first,
  input  logic [CNT_W-1:0]   last,
  input  logic [DWELL_W-1:0] dwell,
  output logic               busy,
  output logic               done,
  output logic               strobe,
  output logic [CNT_W-1:0]   count,
  output logic [SEL_N-1:0]   select
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t               state_q,     state_d;
  logic [CNT_W-1:0]     count_q,     count_d;
  logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
  logic [CNT_W-1:0]     first_q,     first_d;
  logic [CNT_W-1:0]     last_q,      last_d;
  logic [DWELL_W-1:0]   dwell_q,     dwell_d;
  logic                 busy_q,      busy_d;
  logic                 done_q,      done_d;
  logic                 strobe_q,    strobe_d;
  logic [SEL_N-1:0]     select_q,    select_d;

  // Select bus is only driven while the next state is ACTIVE.
  logic                 sel_en_d;

  // Next-state and registered-output computation; everything holds by default,
  // pulses (done/strobe) and busy default low.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    dwell_cnt_d = dwell_cnt_q;
    first_d     = first_q;
    last_d      = last_q;
    dwell_d     = dwell_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    strobe_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // start together with abort is treated as no request at all
        if (start && !abort) begin
          first_d     = first;
          last_d      = last;
          dwell_d     = dwell;
          count_d     = first;
          dwell_cnt_d = dwell;
          busy_d      = 1'b1;
          strobe_d    = 1'b1;
          state_d     = S_ACTIVE;
        end
      end

      S_ACTIVE: begin
        if (abort) begin
          // abort wins over both line advance and completion; count is left
          // where it was so the host can see how far the scan got
          state_d = S_IDLE;
        end else if (dwell_cnt_q != '0) begin
          dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
          busy_d      = 1'b1;
        end else if (count_q == last_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          // natural overflow of count provides the 127 -> 0 wrap
          count_d     = count_q + CNT_W'(1);
          dwell_cnt_d = dwell_q;
          busy_d      = 1'b1;
          strobe_d    = 1'b1;
        end
      end

      S_DONE: begin
        // single-cycle completion state; start/abort are not looked at here
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign sel_en_d = (state_d == S_ACTIVE);

  // One-cold decode of the next count; one comparator per select line so the
  // low bit and the count index can never disagree.
  for (genvar i = 0; i < SEL_N; i++) begin : g_dec
    always_comb select_d[i] = ~(sel_en_d && (count_d == CNT_W'(i)));
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      dwell_cnt_q <= '0;
      first_q     <= '0;
      last_q      <= '0;
      dwell_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      strobe_q    <= 1'b0;
      select_q    <= '1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      dwell_cnt_q <= dwell_cnt_d;
      first_q     <= first_d;
      last_q      <= last_d;
      dwell_q     <= dwell_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      strobe_q    <= strobe_d;
      select_q    <= select_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign strobe = strobe_q;
  assign count  = count_q;
  assign select = select_q;

  // first_q is kept for observability of the accepted range; it has no
  // further use once count is loaded.
  logic unused_first;
  assign unused_first = ^first_q;

endmodule
